// File: rtl/next_address_ras.sv
// next_address_ras
// Owns the program counter and computes the next fetch address every cycle.
// The next address comes from sequential increment, conditional branch,
// absolute jump, register jump, or a circular return-address stack (RAS).
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset (priority over stall)
//   stall         hold pc, RAS and sticky flags
//   zero_flag     ALU zero flag
//   carry_flag    ALU carry flag
//   msb           ALU result sign bit
//   branch_label  signed word offset for conditional branches
//   brtype        branch condition (used only when pc_sel = 0)
//   jmp_ra        register jump target, also the fallback for a return on empty RAS
//   jmp_label     absolute jump label
//   pc_sel        0 seq/branch, 1 jump label, 2 jump register, 3 return
//   call          with pc_sel 1/2/3: push the link address (pc + 1)
//   pc            registered current PC
//   incr_pc       combinational next PC
//   taken         combinational: next PC is not the pc + 1 path
//   ras_count     number of valid RAS entries
//   ras_overflow  sticky: push while full
//   ras_underflow sticky: pop while empty
module next_address_ras #(
  parameter int                ADDR_W    = 32,
  parameter int                BR_W      = 16,
  parameter int                JMP_W     = 26,
  parameter int                RAS_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC  = {ADDR_W{1'b0}}
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic                         zero_flag,
  input  logic                         carry_flag,
  input  logic                         msb,
  input  logic [BR_W-1:0]              branch_label,
  input  logic [2:0]                   brtype,
  input  logic [ADDR_W-1:0]            jmp_ra,
  input  logic [JMP_W-1:0]             jmp_label,
  input  logic [1:0]                   pc_sel,
  input  logic                         call,
  output logic [ADDR_W-1:0]            pc,
  output logic [ADDR_W-1:0]            incr_pc,
  output logic                         taken,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_overflow,
  output logic                         ras_underflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] pc_r;
  logic [CNT_W-1:0]  ras_count_r;
  logic              ras_overflow_r;
  logic              ras_underflow_r;
  logic [ADDR_W-1:0] ras_mem_r [RAS_DEPTH];
  logic [PTR_W-1:0]  top_ptr_r;

  logic [ADDR_W-1:0] seq_s;
  logic [ADDR_W-1:0] br_off_s;
  logic [ADDR_W-1:0] br_target_s;
  logic [ADDR_W-1:0] incr_pc_s;
  logic              taken_s;
  logic              cond_s;
  logic              push_s;
  logic              pop_s;
  logic              ras_empty_s;
  logic              ras_full_s;
  logic [PTR_W-1:0]  push_ptr_s;

  assign seq_s       = pc_r + ADDR_W'(1'b1);
  // Size cast of a signed operand sign-extends the word offset.
  assign br_off_s    = ADDR_W'($signed(branch_label));
  assign br_target_s = seq_s + br_off_s;
  assign ras_empty_s = (ras_count_r == {CNT_W{1'b0}});
  assign ras_full_s  = (ras_count_r == CNT_FULL);
  // Slot above the top wraps onto the oldest entry when the stack is full.
  assign push_ptr_s  = top_ptr_r + PTR_W'(1'b1);
  assign push_s      = call & (pc_sel != 2'd0);
  assign pop_s       = (pc_sel == 2'd3);

  // Branch condition decode.
  always_comb begin
    cond_s = 1'b0;
    case (brtype)
      3'd0:    cond_s = 1'b0;
      3'd1:    cond_s = 1'b1;
      3'd2:    cond_s = zero_flag;
      3'd3:    cond_s = ~zero_flag;
      3'd4:    cond_s = carry_flag;
      3'd5:    cond_s = ~carry_flag;
      3'd6:    cond_s = ~msb;
      3'd7:    cond_s = msb;
      default: cond_s = 1'b0;
    endcase
  end

  // Next-address selection.
  always_comb begin
    incr_pc_s = seq_s;
    taken_s   = 1'b0;
    case (pc_sel)
      2'd0: begin
        if (cond_s) begin
          incr_pc_s = br_target_s;
          taken_s   = 1'b1;
        end else begin
          incr_pc_s = seq_s;
          taken_s   = 1'b0;
        end
      end
      2'd1: begin
        incr_pc_s = {seq_s[ADDR_W-1:JMP_W], jmp_label};
        taken_s   = 1'b1;
      end
      2'd2: begin
        incr_pc_s = jmp_ra;
        taken_s   = 1'b1;
      end
      2'd3: begin
        if (ras_empty_s) begin
          incr_pc_s = jmp_ra;
        end else begin
          incr_pc_s = ras_mem_r[top_ptr_r];
        end
        taken_s = 1'b1;
      end
      default: begin
        incr_pc_s = seq_s;
        taken_s   = 1'b0;
      end
    endcase
  end

  // Program counter, return-address stack and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r            <= RESET_PC;
      ras_count_r     <= {CNT_W{1'b0}};
      top_ptr_r       <= {PTR_W{1'b0}};
      ras_overflow_r  <= 1'b0;
      ras_underflow_r <= 1'b0;
    end else if (!stall) begin
      pc_r <= incr_pc_s;
      if (pop_s && push_s) begin
        if (ras_empty_s) begin
          // Nothing to pop: the push alone lands.
          ras_mem_r[push_ptr_s] <= seq_s;
          top_ptr_r             <= push_ptr_s;
          ras_count_r           <= CNT_W'(1'b1);
          ras_underflow_r       <= 1'b1;
        end else begin
          // Pop then push collapses to replacing the top in place.
          ras_mem_r[top_ptr_r] <= seq_s;
        end
      end else if (push_s) begin
        ras_mem_r[push_ptr_s] <= seq_s;
        top_ptr_r             <= push_ptr_s;
        if (ras_full_s) begin
          ras_overflow_r <= 1'b1;
        end else begin
          ras_count_r <= ras_count_r + CNT_W'(1'b1);
        end
      end else if (pop_s) begin
        if (ras_empty_s) begin
          ras_underflow_r <= 1'b1;
        end else begin
          top_ptr_r   <= top_ptr_r - PTR_W'(1'b1);
          ras_count_r <= ras_count_r - CNT_W'(1'b1);
        end
      end
    end
  end

  assign pc            = pc_r;
  assign incr_pc       = incr_pc_s;
  assign taken         = taken_s;
  assign ras_count     = ras_count_r;
  assign ras_overflow  = ras_overflow_r;
  assign ras_underflow = ras_underflow_r;

endmodule
